// File: rtl/add_dsp_pipe_pkg.sv
// Shared helpers for the segmented DSP adder pipeline: segment count and
// saturation constants, returned in a wide word and cast down by the user.
package add_dsp_pipe_pkg;

  localparam int unsigned SAT_MAX_W = 1024;

  typedef logic [SAT_MAX_W-1:0] sat_word_t;

  function automatic int unsigned num_seg(input int unsigned width,
                                          input int unsigned seg_width);
    return (width + seg_width - 1) / seg_width;
  endfunction

  function automatic sat_word_t sat_umax(input int unsigned width);
    sat_word_t r;
    r = '0;
    for (int unsigned i = 0; i < width && i < SAT_MAX_W; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic sat_word_t sat_umin(input int unsigned width);
    sat_word_t r;
    r = '0;
    if (width == 0) r = '0;
    return r;
  endfunction

  // 0111..1 over the low width bits
  function automatic sat_word_t sat_smax(input int unsigned width);
    sat_word_t r;
    r = '0;
    for (int unsigned i = 0; i + 1 < width && i < SAT_MAX_W; i++) r[i] = 1'b1;
    return r;
  endfunction

  // 1000..0 over the low width bits
  function automatic sat_word_t sat_smin(input int unsigned width);
    sat_word_t r;
    r = '0;
    if (width >= 1 && width <= SAT_MAX_W) r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/add_dsp_pipe_seg.sv
// One registered segment of the pipelined adder: adds A and B-or-~B with a
// carry-in and registers sum, carry-out, valid, sub and the operand sign bits.
module add_dsp_seg
  import add_dsp_pipe_pkg::*;
#(
  parameter int unsigned SEG_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic             sub_i,
  input  logic             cin_i,
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             valid_o,
  output logic             sub_o,
  output logic [1:0]       sign_o
);

  logic [SEG_W-1:0] b_eff;
  logic [SEG_W:0]   raw_d;
  logic [SEG_W-1:0] sum_q;
  logic             cout_q, valid_q, sub_q;
  logic [1:0]       sign_q;

  always_comb begin
    b_eff = b_i ^ {SEG_W{sub_i}};
    raw_d = {1'b0, a_i} + {1'b0, b_eff} + {{SEG_W{1'b0}}, cin_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      sub_q   <= 1'b0;
      sign_q  <= '0;
    end else if (!stall_i) begin
      sum_q   <= raw_d[SEG_W-1:0];
      cout_q  <= raw_d[SEG_W];
      valid_q <= valid_i;
      sub_q   <= sub_i;
      sign_q  <= {a_i[SEG_W-1], b_eff[SEG_W-1]};
    end
  end

  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign valid_o = valid_q;
  assign sub_o   = sub_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/add_dsp_pipe.sv
// Carry-pipelined adder/subtractor built from SEG_WIDTH-bit registered
// segments, with skewed operands, deskewed results and optional saturation.
module add_dsp_pipe
  import add_dsp_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned SEG_WIDTH = 24,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned NUM_SEG = num_seg(WIDTH, SEG_WIDTH);
  localparam int unsigned TOP_W   = WIDTH - (NUM_SEG - 1) * SEG_WIDTH;

  localparam logic [WIDTH-1:0] U_MAX = WIDTH'(sat_umax(WIDTH));
  localparam logic [WIDTH-1:0] U_MIN = WIDTH'(sat_umin(WIDTH));
  localparam logic [WIDTH-1:0] S_MAX = WIDTH'(sat_smax(WIDTH));
  localparam logic [WIDTH-1:0] S_MIN = WIDTH'(sat_smin(WIDTH));

  logic [WIDTH-1:0] raw_y;
  logic             top_cout, top_valid, top_sub;
  logic [1:0]       top_sign;
  logic             ovf;
  logic [WIDTH-1:0] y_sat;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_st
    localparam int unsigned LO_W = k * SEG_WIDTH;
    localparam int unsigned RW   = WIDTH - LO_W;
    localparam int unsigned SW   = (k == NUM_SEG - 1) ? TOP_W : SEG_WIDTH;

    logic [RW-1:0]      a_rem, b_rem;
    logic               v_in, s_in, c_in;
    logic [SW-1:0]      sum;
    logic [LO_W+SW-1:0] res;
    logic               cout, v, s;

    // Stage 0 takes the ports; later stages take the skewed operands and
    // the previous stage's registered carry, sub and valid.
    if (k == 0) begin : g_src
      assign a_rem = a_i;
      assign b_rem = b_i;
      assign v_in  = valid_i;
      assign s_in  = sub_i;
      assign c_in  = sub_i;
      assign res   = sum;
    end else begin : g_src
      logic [LO_W-1:0] lo_q;

      always_ff @(posedge clk_i) begin
        if (rst_i)         lo_q <= '0;
        else if (!stall_i) lo_q <= g_st[k-1].res;
      end

      assign a_rem = g_st[k-1].g_skew.a_q;
      assign b_rem = g_st[k-1].g_skew.b_q;
      assign v_in  = g_st[k-1].v;
      assign s_in  = g_st[k-1].s;
      assign c_in  = g_st[k-1].cout;
      assign res   = {sum, lo_q};
    end

    if (k < NUM_SEG - 1) begin : g_skew
      logic [RW-SW-1:0] a_q, b_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall_i) begin
          a_q <= a_rem[RW-1:SW];
          b_q <= b_rem[RW-1:SW];
        end
      end
    end

    if (k == NUM_SEG - 1) begin : g_seg
      add_dsp_seg #(.SEG_W(SW)) u_seg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stall_i(stall_i),
        .valid_i(v_in),
        .sub_i  (s_in),
        .cin_i  (c_in),
        .a_i    (a_rem[SW-1:0]),
        .b_i    (b_rem[SW-1:0]),
        .sum_o  (sum),
        .cout_o (cout),
        .valid_o(v),
        .sub_o  (s),
        .sign_o (top_sign)
      );

      assign raw_y     = res;
      assign top_cout  = cout;
      assign top_valid = v;
      assign top_sub   = s;
    end else begin : g_seg
      logic [1:0] sign_unused;

      add_dsp_seg #(.SEG_W(SW)) u_seg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stall_i(stall_i),
        .valid_i(v_in),
        .sub_i  (s_in),
        .cin_i  (c_in),
        .a_i    (a_rem[SW-1:0]),
        .b_i    (b_rem[SW-1:0]),
        .sum_o  (sum),
        .cout_o (cout),
        .valid_o(v),
        .sub_o  (s),
        .sign_o (sign_unused)
      );
    end
  end

  // Overflow and clamp are combinational on the last stage's registers, so
  // they hold under stall and read zero straight after reset.
  always_comb begin
    if (SIGNED != 0) begin
      ovf = (top_sign[1] == top_sign[0]) && (raw_y[WIDTH-1] != top_sign[1]);
    end else begin
      ovf = top_sub ? !top_cout : top_cout;
    end

    y_sat = raw_y;
    if (SATURATE != 0 && ovf) begin
      if (SIGNED != 0) y_sat = top_sign[1] ? S_MIN : S_MAX;
      else             y_sat = top_sub ? U_MIN : U_MAX;
    end
  end

  assign valid_o    = top_valid;
  assign y_o        = y_sat;
  assign carry_o    = top_cout;
  assign overflow_o = ovf;

endmodule

// File: tb/tb_add_dsp_pipe.sv
// Directed bench for add_dsp_pipe: four parameterisations side by side,
// single-op vectors, a stalled stream and a reset with operations in flight.
module tb_add_dsp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, vin, sub;
  logic [63:0] a, b;
  logic [29:0] a30, b30;

  logic        vd, cd, od, vs, cs, os, vq, cq, oq, v30, c30, o30;
  logic [63:0] yd, ys, yq;
  logic [29:0] y30;

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;

  add_dsp_pipe u_def (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .valid_i(vin), .sub_i(sub),
    .a_i(a), .b_i(b), .valid_o(vd), .y_o(yd), .carry_o(cd), .overflow_o(od));

  add_dsp_pipe #(.SATURATE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .valid_i(vin), .sub_i(sub),
    .a_i(a), .b_i(b), .valid_o(vs), .y_o(ys), .carry_o(cs), .overflow_o(os));

  add_dsp_pipe #(.SIGNED(1), .SATURATE(1)) u_ssat (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .valid_i(vin), .sub_i(sub),
    .a_i(a), .b_i(b), .valid_o(vq), .y_o(yq), .carry_o(cq), .overflow_o(oq));

  add_dsp_pipe #(.WIDTH(30), .SEG_WIDTH(24)) u_w30 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .valid_i(vin), .sub_i(sub),
    .a_i(a30), .b_i(b30), .valid_o(v30), .y_o(y30), .carry_o(c30), .overflow_o(o30));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] a, b;
    logic        sub;
    logic [63:0] yd;
    logic        cd, od;
    logic [63:0] ysat, yss;
    logic        css, oss;
    logic [29:0] a30, b30, y30;
    logic        c30, o30;
  } vec_t;

  vec_t vecs[5];

  logic [63:0] sa[4], sb[4], sy[4];
  logic        ss[4];
  logic        st_stall[10];
  int          st_op[10], st_out[10];

  initial begin
    vecs[0] = '{64'h0000_0000_00FF_FFFF, 64'd1, 1'b0,
                64'h0000_0000_0100_0000, 1'b0, 1'b0,
                64'h0000_0000_0100_0000, 64'h0000_0000_0100_0000, 1'b0, 1'b0,
                30'h3FFF_FFFF, 30'd1, 30'd0, 1'b1, 1'b1};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'd0, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                30'd5, 30'd3, 30'd8, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                30'h2AAA_AAAA, 30'h1555_5555, 30'h3FFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{64'd5, 64'd7, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1,
                64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0,
                30'd1, 30'd2, 30'h3FFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
                30'h100_0000, 30'd1, 30'hFF_FFFF, 1'b1, 1'b0};

    sa = '{64'd1, 64'h00FF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'd10};
    sb = '{64'd2, 64'h00FF_FFFF, 64'h1111_1111_1111_1111, 64'd3};
    ss = '{1'b0, 1'b0, 1'b0, 1'b1};
    sy = '{64'd3, 64'h01FF_FFFE, 64'h2345_6789_ABCD_F001, 64'd7};
    st_stall = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    st_op    = '{0, 1, 2, 2, 2, 3, -1, -1, -1, -1};
    st_out   = '{-1, -1, -1, -1, 0, 1, 1, 2, 3, -1};

    rst = 1'b1; stall = 1'b0; vin = 1'b0; sub = 1'b0;
    a = '0; b = '0; a30 = '0; b30 = '0;
    tick();
    tick();
    check("rst_valid", 64'(vd), 64'd0);
    check("rst_y", yd, 64'd0);
    check("rst_carry", 64'(cd), 64'd0);
    check("rst_ovf", 64'(od), 64'd0);
    check("rst_valid30", 64'(v30), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub;
      a30 = vecs[i].a30; b30 = vecs[i].b30;
      vin = 1'b1;
      tick();
      vin = 1'b0;
      check($sformatf("v%0d_w30_lat1", i), 64'(v30), 64'd0);
      check($sformatf("v%0d_def_lat1", i), 64'(vd), 64'd0);
      tick();
      check($sformatf("v%0d_w30_valid", i), 64'(v30), 64'd1);
      check($sformatf("v%0d_w30_y", i), 64'(y30), 64'(vecs[i].y30));
      check($sformatf("v%0d_w30_carry", i), 64'(c30), 64'(vecs[i].c30));
      check($sformatf("v%0d_w30_ovf", i), 64'(o30), 64'(vecs[i].o30));
      check($sformatf("v%0d_def_lat2", i), 64'(vd), 64'd0);
      tick();
      check($sformatf("v%0d_def_valid", i), 64'(vd), 64'd1);
      check($sformatf("v%0d_def_y", i), yd, vecs[i].yd);
      check($sformatf("v%0d_def_carry", i), 64'(cd), 64'(vecs[i].cd));
      check($sformatf("v%0d_def_ovf", i), 64'(od), 64'(vecs[i].od));
      check($sformatf("v%0d_sat_valid", i), 64'(vs), 64'd1);
      check($sformatf("v%0d_sat_y", i), ys, vecs[i].ysat);
      check($sformatf("v%0d_sat_carry", i), 64'(cs), 64'(vecs[i].cd));
      check($sformatf("v%0d_sat_ovf", i), 64'(os), 64'(vecs[i].od));
      check($sformatf("v%0d_ssat_valid", i), 64'(vq), 64'd1);
      check($sformatf("v%0d_ssat_y", i), yq, vecs[i].yss);
      check($sformatf("v%0d_ssat_carry", i), 64'(cq), 64'(vecs[i].css));
      check($sformatf("v%0d_ssat_ovf", i), 64'(oq), 64'(vecs[i].oss));
    end

    // Stream of four ops with a two-cycle stall mid-stream and one more
    // stall while a result is on the output.
    for (int e = 0; e < 10; e++) begin
      stall = st_stall[e];
      if (st_op[e] >= 0) begin
        vin = 1'b1;
        a = sa[st_op[e]]; b = sb[st_op[e]]; sub = ss[st_op[e]];
      end else begin
        vin = 1'b0;
      end
      tick();
      check($sformatf("stream_e%0d_valid", e), 64'(vd), 64'(st_out[e] >= 0));
      if (st_out[e] >= 0) check($sformatf("stream_e%0d_y", e), yd, sy[st_out[e]]);
    end
    stall = 1'b0; vin = 1'b0;

    // Reset with two ops in flight, asserted together with stall and valid.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; sub = 1'b0; vin = 1'b1;
    tick();
    a = 64'd200; b = 64'd2;
    tick();
    rst = 1'b1; stall = 1'b1;
    tick();
    check("inflight_rst_valid", 64'(vd), 64'd0);
    check("inflight_rst_y", yd, 64'd0);
    check("inflight_rst_carry", 64'(cd), 64'd0);
    check("inflight_rst_ovf", 64'(od), 64'd0);
    rst = 1'b0; stall = 1'b0; vin = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("post_rst_e%0d_valid", e), 64'(vd), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
